// File: rtl/block_sad_search.sv
// Block SAD disparity search: accumulates one 6x6 SAD row per cycle and tracks the minimum across a search.
// Optional macro SAD_THRESHOLD_EN marks low-confidence results with an all-ones disparity.
module block_sad_search #(
    parameter int BLOCK_SIZE    = 6,
    parameter int MAX_DISPARITY = 16
`ifdef SAD_THRESHOLD_EN
    , parameter int SAD_THRESHOLD = 4000
`endif
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   valid_in,
    input  logic                                   first_in,
    input  logic                                   last_in,
    input  logic                                   read_front,
    input  logic [BLOCK_SIZE-1:0][8*BLOCK_SIZE-1:0] left_front_buffer,
    input  logic [BLOCK_SIZE-1:0][8*BLOCK_SIZE-1:0] left_back_buffer,
    input  logic [BLOCK_SIZE-1:0][8*BLOCK_SIZE-1:0] right_front_buffer,
    input  logic [BLOCK_SIZE-1:0][8*BLOCK_SIZE-1:0] right_back_buffer,
    output logic                                   ready_out,
    output logic [13:0]                            sad_out,
    output logic                                   sad_valid,
    output logic [$clog2(MAX_DISPARITY)-1:0]       best_disparity,
    output logic [13:0]                            best_sad,
    output logic                                   result_valid,
    output logic                                   overflow_out
);

    localparam int IDX_W = $clog2(MAX_DISPARITY);
    localparam int ROW_W = $clog2(BLOCK_SIZE);

    typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, RESULT} state_t;

    state_t                                  state_q, state_d;
    logic [BLOCK_SIZE-1:0][8*BLOCK_SIZE-1:0] left_q, left_d, right_q, right_d;
    logic                                    first_q, first_d, last_q, last_d;
    logic                                    open_q, open_d, overflow_q, overflow_d;
    logic [ROW_W-1:0]                        row_q, row_d;
    logic [13:0]                             acc_q, acc_d, sad_q, sad_d;
    logic [13:0]                             best_sad_q, best_sad_d;
    logic [IDX_W-1:0]                        index_q, index_d, best_disp_q, best_disp_d;
    logic [IDX_W-1:0]                        cand_idx;
    logic [10:0]                             row_sum;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        row_sum = '0;
        for (int p = 0; p < BLOCK_SIZE; p++) begin
            row_sum = row_sum + {3'b000, abs_diff(left_q[row_q][8*p +: 8], right_q[row_q][8*p +: 8])};
        end
    end

    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        right_d     = right_q;
        first_d     = first_q;
        last_d      = last_q;
        open_d      = open_q;
        overflow_d  = overflow_q;
        row_d       = row_q;
        acc_d       = acc_q;
        sad_d       = sad_q;
        best_sad_d  = best_sad_q;
        best_disp_d = best_disp_q;
        index_d     = index_q;
        cand_idx    = '0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    left_d  = read_front ? left_front_buffer  : left_back_buffer;
                    right_d = read_front ? right_front_buffer : right_back_buffer;
                    first_d = first_in;
                    last_d  = last_in;
                    acc_d   = '0;
                    row_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + {3'b000, row_sum};
                row_d = row_q + ROW_W'(1);
                if (row_q == ROW_W'(BLOCK_SIZE - 1)) begin
                    sad_d   = acc_q + {3'b000, row_sum};
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                // A first candidate (or one with no open search) restarts the search; it also abandons any open one.
                if (first_q || !open_q) begin
                    index_d     = '0;
                    best_sad_d  = sad_q;
                    best_disp_d = '0;
                    overflow_d  = 1'b0;
                end else begin
                    if (index_q == IDX_W'(MAX_DISPARITY - 1)) begin
                        cand_idx   = index_q;
                        overflow_d = 1'b1;
                    end else begin
                        cand_idx = index_q + IDX_W'(1);
                    end
                    index_d = cand_idx;
                    if (sad_q < best_sad_q) begin
                        best_sad_d  = sad_q;
                        best_disp_d = cand_idx;
                    end
                end
                open_d = 1'b1;
                if (last_q) begin
                    open_d  = 1'b0;
                    state_d = RESULT;
`ifdef SAD_THRESHOLD_EN
                    if (best_sad_d > 14'(SAD_THRESHOLD)) begin
                        best_disp_d = '1;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            left_q      <= '0;
            right_q     <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            open_q      <= 1'b0;
            overflow_q  <= 1'b0;
            row_q       <= '0;
            acc_q       <= '0;
            sad_q       <= '0;
            best_sad_q  <= '0;
            best_disp_q <= '0;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            right_q     <= right_d;
            first_q     <= first_d;
            last_q      <= last_d;
            open_q      <= open_d;
            overflow_q  <= overflow_d;
            row_q       <= row_d;
            acc_q       <= acc_d;
            sad_q       <= sad_d;
            best_sad_q  <= best_sad_d;
            best_disp_q <= best_disp_d;
            index_q     <= index_d;
        end
    end

    assign ready_out      = (state_q == IDLE);
    assign sad_valid      = (state_q == COMPARE);
    assign result_valid   = (state_q == RESULT);
    assign sad_out        = sad_q;
    assign best_sad       = best_sad_q;
    assign best_disparity = best_disp_q;
    assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_block_sad_search.sv
// Directed self-checking bench for block_sad_search; expected SADs are hand-computed per test.
module tb_block_sad_search;

    logic             clk_in = 1'b0;
    logic             rst_in, valid_in, first_in, last_in, read_front;
    logic [5:0][47:0] left_front_buffer, left_back_buffer;
    logic [5:0][47:0] right_front_buffer, right_back_buffer;
    logic             ready_out, sad_valid, result_valid, overflow_out;
    logic [13:0]      sad_out, best_sad;
    logic [3:0]       best_disparity;

    int vectors    = 0;
    int miscompares = 0;
    int pulses;
    logic [3:0] maxDispExp;

    block_sad_search dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in),
        .first_in(first_in), .last_in(last_in), .read_front(read_front),
        .left_front_buffer(left_front_buffer), .left_back_buffer(left_back_buffer),
        .right_front_buffer(right_front_buffer), .right_back_buffer(right_back_buffer),
        .ready_out(ready_out), .sad_out(sad_out), .sad_valid(sad_valid),
        .best_disparity(best_disparity), .best_sad(best_sad),
        .result_valid(result_valid), .overflow_out(overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Left front zero; right front pixels filled greedily so the block SAD equals target.
    task automatic makeSad(input int target);
        int remaining;
        remaining = target;
        left_front_buffer = '0;
        left_back_buffer  = '0;
        right_back_buffer = '0;
        right_front_buffer = '0;
        for (int r = 0; r < 6; r++) begin
            for (int p = 0; p < 6; p++) begin
                right_front_buffer[r][8*p +: 8] = 8'((remaining > 255) ? 255 : remaining);
                remaining = remaining - ((remaining > 255) ? 255 : remaining);
            end
        end
    endtask

    // Presents one candidate and returns in its COMPARE cycle.
    task automatic applyStimulus(input logic f, input logic l, input logic rf);
        valid_in   = 1'b1;
        first_in   = f;
        last_in    = l;
        read_front = rf;
        tick();
        valid_in = 1'b0;
        first_in = 1'b0;
        last_in  = 1'b0;
        checkOutput("ready_low_accum", 32'(ready_out), 32'd0);
        repeat (5) tick();
        checkOutput("no_early_sad_valid", 32'(sad_valid), 32'd0);
        tick();
        checkOutput("sad_valid_pulse", 32'(sad_valid), 32'd1);
    endtask

    initial begin
`ifdef SAD_THRESHOLD_EN
        maxDispExp = 4'hF;
`else
        maxDispExp = 4'h0;
`endif
        rst_in = 1'b1; valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0; read_front = 1'b1;
        left_front_buffer = '0; left_back_buffer = '0;
        right_front_buffer = '0; right_back_buffer = '0;
        tick();
        tick();
        checkOutput("rst_ready", 32'(ready_out), 32'd1);
        checkOutput("rst_sad_out", 32'(sad_out), 32'd0);
        checkOutput("rst_sad_valid", 32'(sad_valid), 32'd0);
        checkOutput("rst_best_disp", 32'(best_disparity), 32'd0);
        checkOutput("rst_best_sad", 32'(best_sad), 32'd0);
        checkOutput("rst_result_valid", 32'(result_valid), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_out), 32'd0);
        rst_in = 1'b0;
        tick();

        // Identical blocks
        left_front_buffer = {36{8'h40}};
        right_front_buffer = {36{8'h40}};
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("ident_sad", 32'(sad_out), 32'd0);
        tick();
        checkOutput("ident_result_valid", 32'(result_valid), 32'd1);
        checkOutput("ident_best_disp", 32'(best_disparity), 32'd0);
        checkOutput("ident_best_sad", 32'(best_sad), 32'd0);
        tick();
        checkOutput("ident_ready_back", 32'(ready_out), 32'd1);
        checkOutput("ident_result_once", 32'(result_valid), 32'd0);

        // Maximum difference, left > right
        left_front_buffer = {36{8'hFF}};
        right_front_buffer = '0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("max_sad", 32'(sad_out), 32'd9180);
        tick();
        checkOutput("max_best_sad", 32'(best_sad), 32'd9180);
        checkOutput("max_best_disp", 32'(best_disparity), 32'(maxDispExp));
        tick();

        // Buffer select, right > left in back copy
        left_front_buffer = '0; right_front_buffer = '0;
        left_back_buffer = {36{8'h10}}; right_back_buffer = {36{8'h12}};
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("back_sad", 32'(sad_out), 32'd72);
        tick(); tick();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("front_sad", 32'(sad_out), 32'd0);
        tick(); tick();

        // Row r pixels all r+1: 6*(1+2+...+6) = 126
        left_front_buffer = '0; left_back_buffer = '0; right_back_buffer = '0;
        for (int r = 0; r < 6; r++) right_front_buffer[r] = {6{8'(r + 1)}};
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("rows_sad", 32'(sad_out), 32'd126);
        tick(); tick();

        // Four-candidate search 500, 120, 120, 300
        makeSad(500);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("s4_c0_sad", 32'(sad_out), 32'd500);
        tick();
        checkOutput("s4_c0_no_result", 32'(result_valid), 32'd0);
        makeSad(120);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("s4_c1_sad", 32'(sad_out), 32'd120);
        tick();
        checkOutput("s4_c1_no_result", 32'(result_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("s4_c2_no_result", 32'(result_valid), 32'd0);
        makeSad(300);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("s4_c3_sad", 32'(sad_out), 32'd300);
        tick();
        checkOutput("s4_result_valid", 32'(result_valid), 32'd1);
        checkOutput("s4_best_disp", 32'(best_disparity), 32'd1);
        checkOutput("s4_best_sad", 32'(best_sad), 32'd120);
        tick();

        // Abandoned search: second first_in restarts, best reflects only the new search
        makeSad(50);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick();
        makeSad(200);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("abandon_best_sad", 32'(best_sad), 32'd200);
        checkOutput("abandon_best_disp", 32'(best_disparity), 32'd0);
        tick();

        // valid_in held during ACCUM must not start another candidate
        makeSad(33);
        valid_in = 1'b1; first_in = 1'b1; last_in = 1'b1; read_front = 1'b1;
        tick();
        repeat (3) tick();
        valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0;
        pulses = 0;
        repeat (12) begin
            tick();
            if (sad_valid) pulses++;
        end
        checkOutput("ignored_valid_pulses", 32'(pulses), 32'd1);
        checkOutput("ignored_valid_sad", 32'(sad_out), 32'd33);

        // 17 candidates: SAD 1000-10*i for i<16, then 900
        for (int i = 0; i < 17; i++) begin
            makeSad((i < 16) ? (1000 - 10 * i) : 900);
            applyStimulus(i == 0, i == 16, 1'b1);
            tick();
            if (i == 15) checkOutput("ovf_not_yet", 32'(overflow_out), 32'd0);
        end
        checkOutput("ovf_result_valid", 32'(result_valid), 32'd1);
        checkOutput("ovf_set", 32'(overflow_out), 32'd1);
        checkOutput("ovf_best_disp", 32'(best_disparity), 32'd15);
        checkOutput("ovf_best_sad", 32'(best_sad), 32'd850);
        tick();

        // Reset at ACCUM row 3
        makeSad(400);
        valid_in = 1'b1; first_in = 1'b1; last_in = 1'b1;
        tick();
        valid_in = 1'b0; first_in = 1'b0; last_in = 1'b0;
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        checkOutput("midrst_ready", 32'(ready_out), 32'd1);
        checkOutput("midrst_sad_out", 32'(sad_out), 32'd0);
        checkOutput("midrst_best_sad", 32'(best_sad), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow_out), 32'd0);
        checkOutput("midrst_sad_valid", 32'(sad_valid), 32'd0);

        // Fresh candidate after reset: no residue from the discarded sum
        makeSad(77);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("postrst_sad", 32'(sad_out), 32'd77);
        tick();
        checkOutput("postrst_best_sad", 32'(best_sad), 32'd77);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/block_sad_search.md
Name: block_sad_search

Overview:
- Downstream consumer of the 6x6 block window loader (update_buffers).
- Computes the sum of absolute differences (SAD) between a left 6x6 pixel block and a candidate right 6x6 block.
- Processes one row per cycle and tracks the minimum SAD across a sequence of candidates (one disparity search).
- Reports the winning disparity index per left block to the depth-map writer.

Parameters:
- BLOCK_SIZE, 6, rows per block and pixels per row. Fixed at 6, so the row word is 48 bits.
- MAX_DISPARITY, 16, maximum number of candidates per search.
- SAD_THRESHOLD, 4000, confidence limit. Used only when SAD_THRESHOLD_EN is defined.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset
- valid_in  in  1  candidate pair presented; accepted only when ready_out=1
- first_in  in  1  qualifies valid_in; the candidate starts a new search (index 0)
- last_in  in  1  qualifies valid_in; the candidate ends the search
- read_front  in  1  1: snapshot front buffers; 0: snapshot back buffers
- left_front_buffer  in  6x48  left block rows, front copy
- left_back_buffer  in  6x48  left block rows, back copy
- right_front_buffer  in  6x48  right candidate rows, front copy
- right_back_buffer  in  6x48  right candidate rows, back copy
- ready_out  out  1  high in IDLE only
- sad_out  out  14  SAD of the last completed candidate
- sad_valid  out  1  one-cycle pulse with sad_out
- best_disparity  out  4  index of the minimum-SAD candidate; width is $clog2(MAX_DISPARITY)
- best_sad  out  14  SAD of the winning candidate
- result_valid  out  1  one-cycle pulse; the search result is final
- overflow_out  out  1  sticky; the search exceeded MAX_DISPARITY candidates

Behaviour:
- Interface (already decided): one clock, clk_in. rst_in is synchronous and active-high. No other clocks or resets.
- Pixel packing: row r is buffer[r]. Pixel p occupies bits [8p+7:8p], p=0 leftmost. Pixels are 8-bit unsigned.
- Reset values: all outputs 0 except ready_out=1. State is IDLE, the candidate index is 0, and no search is open.
- Reset mid-operation returns to IDLE on the next edge and discards partial sums and the best-so-far.

State machine: IDLE -> ACCUM -> COMPARE -> (RESULT | IDLE); RESULT -> IDLE.
- IDLE, acceptance cycle T:
  - When valid_in=1, register the 6 left rows and 6 right rows selected by read_front.
  - Also register first_in and last_in, clear the accumulator and row counter, and go to ACCUM.
  - The snapshot lets upstream overwrite its buffers from T+1 on.
- ACCUM, T+1..T+6:
  - Row counter 0..5.
  - Each cycle computes the 6 absolute differences |L-R| (8 bits each) for one row.
  - Their row sum is 11 bits (max 1530); add it to the 14-bit accumulator (max 9180, no overflow possible).
  - After row 5, go to COMPARE.
- COMPARE, T+7:
  - Pulse sad_valid with sad_out=accumulator.
  - If the candidate is first, or no search is open: set index=0, best_sad=SAD, best_disparity=0, and clear overflow_out.
  - Otherwise increment the index. Replace best only if SAD < best_sad (strictly less), so ties keep the lower disparity.
  - Index saturates at MAX_DISPARITY-1. A candidate arriving at a saturated index is still compared but sets overflow_out.
  - If last: go to RESULT. Otherwise go to IDLE with the search still open.
- RESULT, T+8: pulse result_valid; best_disparity and best_sad are stable and held until the next search's first COMPARE. Close the search and go to IDLE.
- Timing: latency from acceptance to sad_valid is 7 cycles, and to result_valid 8 cycles. ready_out is low from T+1 until IDLE is re-entered.
- Handshake: valid_in while ready_out=0 is ignored. No queueing.
- first_in and last_in together form a single-candidate search with result index 0.
- first_in arriving while a search is open abandons the old search without a result_valid.

Optional Feature:
- Macro SAD_THRESHOLD_EN.
- Defined: in RESULT, if best_sad > SAD_THRESHOLD, best_disparity is forced to all-ones as a low-confidence marker. best_sad still reports the true minimum.
- Undefined: no threshold check, and the SAD_THRESHOLD parameter is ignored.

Test Plan:
- Identical blocks: all left and right pixels 8'h40, first_in=last_in=1, read_front=1 -> sad_out=0 at T+7; result_valid at T+8 with best_disparity=0, best_sad=0.
- Max difference: left all 8'hFF, right all 8'h00 -> sad_out=9180 (14'h23DC); no wrap; best_sad=9180.
- Buffer select: front buffers all zero, back buffers with left=8'h10, right=8'h12, read_front=0 -> sad_out=72. With read_front=1 -> sad_out=0.
- Four-candidate search with SADs 500, 120, 120, 300 -> best_disparity=1, best_sad=120 (tie keeps lower index). result_valid pulses once, after the 4th candidate only.
- Protocol: valid_in asserted during ACCUM is ignored (no extra sad_valid). rst_in at ACCUM row 3 -> ready_out=1 and outputs 0 next cycle. 17 candidates with MAX_DISPARITY=16 -> overflow_out=1.
- With SAD_THRESHOLD_EN and SAD_THRESHOLD=4000, single candidate SAD 9180 -> best_disparity=4'hF, best_sad=9180. Without the macro -> best_disparity=0.
